nf10_axis_port_stats: RTL and testbench

//  Passive, parametrised statistics tap on the AXI4-Stream path between output_port_lookup and the output queues.

---
 rtl/nf10_axis_port_stats.sv | 257 +++++++++++++++++++++++++
 tb/tb_nf10_axis_port_stats.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf10_axis_port_stats.sv
// ============================================================================
// nf10_axis_port_stats : passive AXI4-Stream per-source-port packet/byte stats
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module nf10_axis_port_stats #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_PORTS            = 8,
  parameter int SRC_PORT_POS         = 16,
  parameter int CNTR_WIDTH           = 32,
  parameter int PKT_LEN_WIDTH        = 16,
  parameter int SATURATE             = 0,
  parameter int RD_ADDR_WIDTH        = 6
) (
  input  logic                              axi_aclk,
  input  logic                              axi_reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  input  logic                              lut_hit,
  input  logic                              lut_miss,
  input  logic                              rst_cntrs,
  input  logic                              rd_en,
  input  logic [RD_ADDR_WIDTH-1:0]          rd_addr,
  output logic [CNTR_WIDTH-1:0]             rd_data,
  output logic                              rd_valid,
  output logic                              ovf_any
);

  localparam int STRB_W      = C_S_AXIS_DATA_WIDTH / 8;
  localparam int BEAT_W      = $clog2(STRB_W + 1);
  localparam int CH_W        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int NUM_CNT     = 2 * NUM_PORTS + 3;
  localparam int HIT_IDX     = 2 * NUM_PORTS;
  localparam int MISS_IDX    = 2 * NUM_PORTS + 1;
  localparam int UNK_IDX     = 2 * NUM_PORTS + 2;
  localparam int STATUS_ADDR = 2 * NUM_PORTS + 3;
  localparam int STAT_N      = (CNTR_WIDTH < NUM_CNT) ? CNTR_WIDTH : NUM_CNT;
  localparam int INC_W       = (CNTR_WIDTH > PKT_LEN_WIDTH) ? CNTR_WIDTH : PKT_LEN_WIDTH;
  localparam int SUM_W       = INC_W + 1;
  localparam int ACC_SUM_W   = ((PKT_LEN_WIDTH > BEAT_W) ? PKT_LEN_WIDTH : BEAT_W) + 1;

  localparam logic [PKT_LEN_WIDTH-1:0] ACC_MAX = {PKT_LEN_WIDTH{1'b1}};
  localparam logic [CNTR_WIDTH-1:0]    CNT_MAX = {CNTR_WIDTH{1'b1}};

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  logic unused_inputs;
  assign unused_inputs = ^{s_axis_tdata, s_axis_tuser};

  logic                  beat;
  logic [BEAT_W-1:0]     beat_bytes;
  logic [NUM_PORTS-1:0]  src_field;
  logic [CH_W-1:0]       src_ch;
  logic                  src_known;

  assign beat      = s_axis_tvalid & s_axis_tready;
  assign src_field = s_axis_tuser[SRC_PORT_POS +: NUM_PORTS];

  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < STRB_W; i++) begin
      beat_bytes = beat_bytes + BEAT_W'(s_axis_tstrb[i]);
    end
  end

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    src_ch    = '0;
    src_known = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (src_field[i]) begin
        src_ch    = CH_W'(i);
        src_known = 1'b1;
      end
    end
  end

  state_t                    state_q, state_d;
  logic [PKT_LEN_WIDTH-1:0]  acc_q, acc_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic                      known_q, known_d;
  logic                      commit_q, commit_d;
  logic [CH_W-1:0]           commit_ch_q, commit_ch_d;
  logic                      commit_known_q, commit_known_d;
  logic [PKT_LEN_WIDTH-1:0]  commit_len_q, commit_len_d;

  logic [ACC_SUM_W-1:0]      acc_sum;
  logic [PKT_LEN_WIDTH-1:0]  acc_next;
  logic [CH_W-1:0]           pkt_ch;
  logic                      pkt_known;

  assign acc_sum   = ((state_q == IN_PKT) ? ACC_SUM_W'(acc_q) : ACC_SUM_W'(0)) + ACC_SUM_W'(beat_bytes);
  assign acc_next  = (acc_sum > ACC_SUM_W'(ACC_MAX)) ? ACC_MAX : acc_sum[PKT_LEN_WIDTH-1:0];
  assign pkt_ch    = (state_q == IDLE) ? src_ch    : ch_q;
  assign pkt_known = (state_q == IDLE) ? src_known : known_q;

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    ch_d           = ch_q;
    known_d        = known_q;
    commit_d       = 1'b0;
    commit_ch_d    = commit_ch_q;
    commit_known_d = commit_known_q;
    commit_len_d   = commit_len_q;
    if (beat) begin
      acc_d   = acc_next;
      ch_d    = pkt_ch;
      known_d = pkt_known;
      if (s_axis_tlast) begin
        state_d        = IDLE;
        commit_d       = 1'b1;
        commit_ch_d    = pkt_ch;
        commit_known_d = pkt_known;
        commit_len_d   = acc_next;
      end else begin
        state_d = IN_PKT;
      end
    end
  end

  // Packet tracking is independent of rst_cntrs so an in-flight packet survives a clear.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      ch_q           <= '0;
      known_q        <= 1'b0;
      commit_q       <= 1'b0;
      commit_ch_q    <= '0;
      commit_known_q <= 1'b0;
      commit_len_q   <= '0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      ch_q           <= ch_d;
      known_q        <= known_d;
      commit_q       <= commit_d;
      commit_ch_q    <= commit_ch_d;
      commit_known_q <= commit_known_d;
      commit_len_q   <= commit_len_d;
    end
  end

  logic [CNTR_WIDTH-1:0] cnt_arr [NUM_CNT];
  logic                  ovf_arr [NUM_CNT];

  for (genvar k = 0; k < NUM_CNT; k++) begin : g_cntr
    logic [INC_W-1:0]      inc;
    logic [SUM_W-1:0]      sum;
    logic [CNTR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;

    if (k < 2 * NUM_PORTS) begin : g_port
      logic port_commit;
      assign port_commit = commit_q & commit_known_q & (commit_ch_q == CH_W'(k / 2));
      if (k % 2 == 0) begin : g_pkt
        assign inc = INC_W'(port_commit);
      end else begin : g_byte
        assign inc = port_commit ? INC_W'(commit_len_q) : INC_W'(0);
      end
    end else if (k == HIT_IDX) begin : g_hit
      assign inc = INC_W'(lut_hit);
    end else if (k == MISS_IDX) begin : g_miss
      assign inc = INC_W'(lut_miss);
    end else begin : g_unk
      assign inc = INC_W'(commit_q & ~commit_known_q);
    end

    assign sum = SUM_W'(cnt_q) + SUM_W'(inc);

    always_comb begin
      cnt_d = sum[CNTR_WIDTH-1:0];
      ovf_d = ovf_q;
      if (rst_cntrs) begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end else if (sum > SUM_W'(CNT_MAX)) begin
        ovf_d = 1'b1;
        if (SATURATE != 0) begin
          cnt_d = CNT_MAX;
        end
      end
    end

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
      if (axi_reset) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
      end
    end

    assign cnt_arr[k] = cnt_q;
    assign ovf_arr[k] = ovf_q;
  end

  logic [CNTR_WIDTH-1:0] status_word;
  logic [CNTR_WIDTH-1:0] rd_word;
  logic [CNTR_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  always_comb begin
    status_word = '0;
    for (int k = 0; k < STAT_N; k++) begin
      status_word[k] = ovf_arr[k];
    end
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (rd_addr == RD_ADDR_WIDTH'(k)) begin
        rd_word = cnt_arr[k];
      end
    end
    if (rd_addr == RD_ADDR_WIDTH'(STATUS_ADDR)) begin
      rd_word = status_word;
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= rd_word;
      end
    end
  end

  always_comb begin
    ovf_any = 1'b0;
    for (int k = 0; k < NUM_CNT; k++) begin
      ovf_any = ovf_any | ovf_arr[k];
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_nf10_axis_port_stats.sv
// ============================================================================
// tb_nf10_axis_port_stats : three parameter variants driven in parallel, checked against a packet-level model
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nf10_axis_port_stats;

  localparam int N      = 8;
  localparam int NC     = 2 * N + 3;
  localparam int STATUS = NC;

  logic         clk = 1'b0;
  logic         axi_reset;
  logic [255:0] tdata;
  logic [31:0]  tstrb;
  logic [127:0] tuser;
  logic         tvalid, tready, tlast;
  logic         lut_hit, lut_miss, rst_cntrs;
  logic         rd_en;
  logic [5:0]   rd_addr;
  logic [31:0]  rd_data0;
  logic [7:0]   rd_data1, rd_data2;
  logic [2:0]   rd_valid, ovf_any;

  always #5 clk = ~clk;

  nf10_axis_port_stats u_dut0 (
    .axi_aclk(clk), .axi_reset(axi_reset), .s_axis_tdata(tdata), .s_axis_tstrb(tstrb),
    .s_axis_tuser(tuser), .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tlast(tlast),
    .lut_hit(lut_hit), .lut_miss(lut_miss), .rst_cntrs(rst_cntrs), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid[0]), .ovf_any(ovf_any[0]));

  nf10_axis_port_stats #(.CNTR_WIDTH(8), .SATURATE(1)) u_dut1 (
    .axi_aclk(clk), .axi_reset(axi_reset), .s_axis_tdata(tdata), .s_axis_tstrb(tstrb),
    .s_axis_tuser(tuser), .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tlast(tlast),
    .lut_hit(lut_hit), .lut_miss(lut_miss), .rst_cntrs(rst_cntrs), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid[1]), .ovf_any(ovf_any[1]));

  nf10_axis_port_stats #(.CNTR_WIDTH(8), .SATURATE(0)) u_dut2 (
    .axi_aclk(clk), .axi_reset(axi_reset), .s_axis_tdata(tdata), .s_axis_tstrb(tstrb),
    .s_axis_tuser(tuser), .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tlast(tlast),
    .lut_hit(lut_hit), .lut_miss(lut_miss), .rst_cntrs(rst_cntrs), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data2), .rd_valid(rd_valid[2]), .ovf_any(ovf_any[2]));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: counter values per variant, updated once per clock edge.
  longint unsigned m_cnt [3][NC];
  bit              m_ovf [3][NC];
  bit              m_in_pkt;
  int              m_ch;
  longint unsigned m_len;
  bit              m_pend;
  int              m_pend_ch;
  longint unsigned m_pend_len;

  function automatic int cw(int j);
    return (j == 0) ? 32 : 8;
  endfunction

  task automatic m_add(int k, longint unsigned v);
    for (int j = 0; j < 3; j++) begin
      longint unsigned mx = (64'd1 << cw(j)) - 1;
      longint unsigned s  = m_cnt[j][k] + v;
      if (s > mx) begin
        m_ovf[j][k] = 1'b1;
        m_cnt[j][k] = (j == 1) ? mx : (s & mx);
      end else begin
        m_cnt[j][k] = s;
      end
    end
  endtask

  task automatic m_clear();
    for (int j = 0; j < 3; j++)
      for (int k = 0; k < NC; k++) begin
        m_cnt[j][k] = 0;
        m_ovf[j][k] = 1'b0;
      end
  endtask

  function automatic int lowest(logic [7:0] f);
    for (int i = 0; i < N; i++) if (f[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (axi_reset) begin
      m_clear();
      m_in_pkt = 1'b0;
      m_pend   = 1'b0;
      m_len    = 0;
    end else begin
      if (m_pend) begin
        if (m_pend_ch < 0) m_add(2 * N + 2, 1);
        else begin
          m_add(2 * m_pend_ch, 1);
          m_add(2 * m_pend_ch + 1, m_pend_len);
        end
        m_pend = 1'b0;
      end
      if (lut_hit)  m_add(2 * N, 1);
      if (lut_miss) m_add(2 * N + 1, 1);
      if (rst_cntrs) m_clear();
      if (tvalid && tready) begin
        if (!m_in_pkt) begin
          m_ch     = lowest(tuser[23:16]);
          m_len    = 0;
          m_in_pkt = 1'b1;
        end
        m_len = m_len + $countones(tstrb);
        if (m_len > 65535) m_len = 65535;
        if (tlast) begin
          m_pend     = 1'b1;
          m_pend_ch  = m_ch;
          m_pend_len = m_len;
          m_in_pkt   = 1'b0;
        end
      end
    end
  end

  function automatic logic [31:0] exp_rd(int j, int a);
    logic [31:0] v = '0;
    if (a < NC) v = 32'(m_cnt[j][a]);
    else if (a == STATUS)
      for (int k = 0; k < NC && k < cw(j); k++) v[k] = m_ovf[j][k];
    return v;
  endfunction

  function automatic logic exp_ovf_any(int j);
    logic o = 1'b0;
    for (int k = 0; k < NC; k++) o |= m_ovf[j][k];
    return o;
  endfunction

  // Stimulus helpers: inputs change just after the falling edge.
  bit side_rand = 1'b0;

  task automatic tick();
    if (side_rand) begin
      lut_hit   = ($urandom % 4) == 0;
      lut_miss  = ($urandom % 5) == 0;
      rst_cntrs = ($urandom % 80) == 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    tvalid = 1'b0; tready = 1'b0; tlast = 1'b0; tstrb = '0;
    lut_hit = 1'b0; lut_miss = 1'b0; rst_cntrs = 1'b0; rd_en = 1'b0;
  endtask

  function automatic logic [127:0] mk_user(logic [7:0] f);
    logic [127:0] u = {$urandom, $urandom, $urandom, $urandom};
    u[23:16] = f;
    return u;
  endfunction

  task automatic set_beat(logic [31:0] strb, logic [7:0] f, logic last);
    tvalid = 1'b1; tready = 1'b1; tlast = last; tstrb = strb;
    tuser  = mk_user(f);
    tdata  = {8{$urandom}};
  endtask

  logic [31:0] got [3];

  task automatic rd_check(int a);
    logic [31:0] e [3];
    logic        eo [3];
    for (int j = 0; j < 3; j++) begin
      e[j]  = exp_rd(j, a);
      eo[j] = exp_ovf_any(j);
    end
    rd_en = 1'b1; rd_addr = 6'(a);
    tick();
    rd_en = 1'b0;
    got[0] = rd_data0; got[1] = {24'd0, rd_data1}; got[2] = {24'd0, rd_data2};
    for (int j = 0; j < 3; j++) begin
      check($sformatf("rd_valid dut%0d", j), {31'd0, rd_valid[j]}, 32'd1);
      check($sformatf("rd[%0d] dut%0d", a, j), got[j], e[j]);
      check($sformatf("ovf_any dut%0d", j), {31'd0, ovf_any[j]}, {31'd0, eo[j]});
    end
  endtask

  task automatic read_all();
    bit sr = side_rand;
    side_rand = 1'b0;
    idle();
    tick(); tick();
    for (int a = 0; a <= STATUS + 1; a++) rd_check(a);
    rd_check(63);
    tick();
    for (int j = 0; j < 3; j++)
      check($sformatf("rd_valid idle dut%0d", j), {31'd0, rd_valid[j]}, 32'd0);
    side_rand = sr;
  endtask

  initial begin
    tdata = '0; tuser = '0; rd_addr = '0;
    idle();
    axi_reset = 1'b1;
    tick(); tick();
    for (int j = 0; j < 3; j++) begin
      check($sformatf("reset rd_valid dut%0d", j), {31'd0, rd_valid[j]}, 32'd0);
      check($sformatf("reset ovf_any dut%0d", j), {31'd0, ovf_any[j]}, 32'd0);
    end
    check("reset rd_data dut0", rd_data0, 32'd0);
    axi_reset = 1'b0;
    tick();

    // 1: 64B packet on port 2
    set_beat('1, 8'h04, 1'b0); tick();
    set_beat('1, 8'h55, 1'b1); tick();
    idle();
    read_all();
    rd_check(4); check("t1 pkt_cnt[2]", got[0], 32'd1);
    rd_check(5); check("t1 byte_cnt[2]", got[0], 32'd64);

    // 2: 72B packet on port 5 then back-to-back 4B packet on port 0
    set_beat('1, 8'h20, 1'b0); tick();
    set_beat('1, 8'h00, 1'b0); tick();
    set_beat(32'h0000_00FF, 8'h00, 1'b1); tick();
    set_beat(32'h0000_000F, 8'h01, 1'b1); tick();
    idle();
    read_all();
    rd_check(11); check("t2 byte_cnt[5]", got[0], 32'd72);
    rd_check(1);  check("t2 byte_cnt[0]", got[0], 32'd4);

    // 3: stalled beat, unknown source
    set_beat('1, 8'h00, 1'b1);
    tready = 1'b0;
    repeat (5) tick();
    tready = 1'b1; tick();
    idle();
    read_all();
    rd_check(18); check("t3 unknown_cnt", got[0], 32'd1);

    // 5: clear coincident with a commit and a hit, packet in flight across it
    set_beat('1, 8'h02, 1'b1); tick();
    set_beat('1, 8'h40, 1'b0); rst_cntrs = 1'b1; lut_hit = 1'b1; tick();
    rst_cntrs = 1'b0; lut_hit = 1'b0;
    set_beat('1, 8'h00, 1'b0); rd_check(2);  check("t5 pkt_cnt[1] cleared", got[0], 32'd0);
    set_beat('1, 8'h00, 1'b1); rd_check(16); check("t5 hit_cnt cleared", got[0], 32'd0);
    idle();
    read_all();
    rd_check(13); check("t5 byte_cnt[6]", got[0], 32'd96);

    // 4: 300 hit pulses
    lut_hit = 1'b1;
    repeat (300) tick();
    idle();
    read_all();
    rd_check(16);
    check("t4 hit sat", got[1], 32'd255);
    check("t4 hit wrap", got[2], 32'd44);
    check("t4 ovf_any sat", {31'd0, ovf_any[1]}, 32'd1);

    // 6: async reset mid-packet
    set_beat('1, 8'h08, 1'b0); tick();
    set_beat('1, 8'h00, 1'b0); tick();
    idle();
    axi_reset = 1'b1;
    #1;
    check("t6 rd_data", rd_data0, 32'd0);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("t6 rd_valid dut%0d", j), {31'd0, rd_valid[j]}, 32'd0);
      check($sformatf("t6 ovf_any dut%0d", j), {31'd0, ovf_any[j]}, 32'd0);
    end
    tick(); tick();
    axi_reset = 1'b0;
    set_beat('1, 8'h08, 1'b0); tick();
    set_beat(32'h0000_FFFF, 8'h00, 1'b1); tick();
    idle();
    read_all();
    rd_check(6); check("t6 pkt_cnt[3]", got[0], 32'd1);
    rd_check(7); check("t6 byte_cnt[3]", got[0], 32'd48);

    // Randomized traffic
    side_rand = 1'b1;
    for (int p = 0; p < 80; p++) begin
      int          nb = $urandom_range(1, 4);
      logic [7:0]  f;
      case ($urandom_range(0, 3))
        0:       f = 8'h00;
        3:       f = 8'($urandom);
        default: f = 8'h01 << $urandom_range(0, 7);
      endcase
      for (int b = 0; b < nb; b++) begin
        logic [31:0] s = ($urandom % 2) ? 32'hFFFF_FFFF : $urandom;
        int          st = $urandom_range(0, 2);
        set_beat(s, (b == 0) ? f : 8'($urandom), b == nb - 1);
        for (int w = 0; w < st; w++) begin
          if ($urandom % 2) tready = 1'b0; else tvalid = 1'b0;
          tick();
          tvalid = 1'b1; tready = 1'b1;
        end
        tick();
      end
      tvalid = 1'b0; tready = 1'b0; tlast = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      if (p == 40) read_all();
    end
    side_rand = 1'b0;
    read_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
